neuron_mac_sequencer: RTL

//  Time-multiplexes one combinational wallace_tree neuron adder across N_NEURONS neurons of N_CHUNKS*N_INPUTS inputs each.

---
 rtl/neuron_mac_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/neuron_mac_sequencer.sv
// Time-multiplexes one combinational wallace-tree adder across a layer of neurons:
// fetches a partial-product word per chunk, accumulates tree sums with saturation, emits one result per neuron.
module neuron_mac_sequencer #(
  parameter int unsigned N_INPUTS    = 4,
  parameter int unsigned WEIGHT_BITS = 3,
  parameter int unsigned INPUT_BITS  = 3,
  parameter int unsigned SUM_BITS    = 9,
  parameter int unsigned N_CHUNKS    = 4,
  parameter int unsigned N_NEURONS   = 8,
  parameter int unsigned ACC_BITS    = 12,
  parameter int unsigned BW_CONST    = 0,
  localparam int unsigned MW  = N_INPUTS * INPUT_BITS * WEIGHT_BITS,
  localparam int unsigned AW  = (N_NEURONS * N_CHUNKS > 1) ? $clog2(N_NEURONS * N_CHUNKS) : 1,
  localparam int unsigned NW  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int unsigned CW  = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1,
  localparam int unsigned BWW = SUM_BITS - INPUT_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [AW-1:0]          mem_addr,
  input  logic [MW-1:0]          mem_rdata,
  output logic [NW-1:0]          bias_addr,
  input  logic [WEIGHT_BITS-1:0] bias_rdata,
  output logic [MW-1:0]          tree_mult,
  output logic [WEIGHT_BITS-1:0] tree_bias,
  output logic [BWW-1:0]         tree_bw,
  input  logic [SUM_BITS-1:0]    tree_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_BITS-1:0]    out_data,
  output logic [NW-1:0]          out_neuron
);

  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ACCUM, OUTPUT} state_t;

  state_t                 state, state_d;
  logic [NW-1:0]          neuron, neuron_d;
  logic [CW-1:0]          chunk, chunk_d;
  logic [ACC_BITS-1:0]    acc, acc_d, acc_sat;
  logic [ACC_BITS:0]      acc_sum;
  logic                   busy_d, done_d, mem_rd_en_d, out_valid_d;
  logic [AW-1:0]          mem_addr_d;
  logic [NW-1:0]          bias_addr_d, out_neuron_d;
  logic [MW-1:0]          tree_mult_d;
  logic [WEIGHT_BITS-1:0] tree_bias_d;
  logic [ACC_BITS-1:0]    out_data_d;

  assign tree_bw = BWW'(BW_CONST);

  // One guard bit catches overflow in either direction; clamp when it disagrees with the sign.
  always_comb begin
    acc_sum = {acc[ACC_BITS-1], acc}
            + {{(ACC_BITS + 1 - SUM_BITS){tree_sum[SUM_BITS-1]}}, tree_sum};
    if (acc_sum[ACC_BITS] != acc_sum[ACC_BITS-1])
      acc_sat = acc_sum[ACC_BITS] ? ACC_MIN : ACC_MAX;
    else
      acc_sat = acc_sum[ACC_BITS-1:0];
  end

  always_comb begin
    state_d      = state;
    neuron_d     = neuron;
    chunk_d      = chunk;
    acc_d        = acc;
    done_d       = 1'b0;
    mem_addr_d   = mem_addr;
    bias_addr_d  = bias_addr;
    tree_mult_d  = tree_mult;
    tree_bias_d  = tree_bias;
    out_data_d   = out_data;
    out_neuron_d = out_neuron;

    case (state)
      IDLE: begin
        // done is still high in the first IDLE cycle; a start then is treated as arriving while busy
        if (start && !done) begin
          state_d  = FETCH;
          neuron_d = '0;
          chunk_d  = '0;
          acc_d    = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        tree_mult_d = mem_rdata;
        tree_bias_d = (chunk == '0) ? bias_rdata : '0;
        state_d     = ACCUM;
      end
      ACCUM: begin
        acc_d = acc_sat;
        if (chunk == CW'(N_CHUNKS - 1)) begin
          state_d      = OUTPUT;
          out_data_d   = acc_sat;
          out_neuron_d = neuron;
        end else begin
          chunk_d = chunk + CW'(1);
          state_d = FETCH;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (neuron == NW'(N_NEURONS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            neuron_d = neuron + NW'(1);
            chunk_d  = '0;
            acc_d    = '0;
            state_d  = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered strobes are derived from the state being entered.
    mem_rd_en_d = (state_d == FETCH);
    out_valid_d = (state_d == OUTPUT);
    busy_d      = (state_d != IDLE);
    if (state_d == FETCH) begin
      mem_addr_d  = AW'(neuron_d) * AW'(N_CHUNKS) + AW'(chunk_d);
      bias_addr_d = neuron_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      neuron     <= '0;
      chunk      <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      bias_addr  <= '0;
      tree_mult  <= '0;
      tree_bias  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_neuron <= '0;
    end else begin
      state      <= state_d;
      neuron     <= neuron_d;
      chunk      <= chunk_d;
      acc        <= acc_d;
      busy       <= busy_d;
      done       <= done_d;
      mem_rd_en  <= mem_rd_en_d;
      mem_addr   <= mem_addr_d;
      bias_addr  <= bias_addr_d;
      tree_mult  <= tree_mult_d;
      tree_bias  <= tree_bias_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_neuron <= out_neuron_d;
    end
  end

endmodule
